// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM; fixed priority (MEM first), or round-robin on contention when ARB_RR_EN is defined.
// Latency: request-to-ack LATENCY+1 cycles; one access per LATENCY+2 cycles. Backpressure: level requests held until the one-cycle ack.
module mem_port_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int LATENCY   = 2,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req,
    input  logic                 mem_req,
    input  logic                 mem_wr,
    input  logic [DATA_SIZE-1:0] ram_rdata,
    output logic                 sel,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic                 if_ack,
    output logic                 mem_ack,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 we_q, we_d;
    logic                 if_ack_q, if_ack_d;
    logic                 mem_ack_q, mem_ack_d;
    logic                 busy_q, busy_d;
    logic [DATA_SIZE-1:0] rd_q, rd_d;
    logic                 grant_mem;

`ifdef ARB_RR_EN
    // last_grant_q: 1 = MEM was granted last; reset to MEM so first contention favours IF
    logic last_grant_q, last_grant_d;

    assign grant_mem = mem_req && (!if_req || !last_grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (if_req || mem_req)) last_grant_d = grant_mem;
    end
`else
    assign grant_mem = mem_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            we_q      <= we_d;
            if_ack_q  <= if_ack_d;
            mem_ack_q <= mem_ack_d;
            busy_q    <= busy_d;
            rd_q      <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        en_d      = en_q;
        we_d      = we_q;
        if_ack_d  = 1'b0;
        mem_ack_d = 1'b0;
        busy_d    = busy_q;
        rd_d      = rd_q;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    sel_d   = grant_mem;
                    en_d    = 1'b1;
                    we_d    = grant_mem && mem_wr;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // we_q low means this was a read (IF, or MEM without write)
                    if (!we_q) rd_d = ram_rdata;
                    en_d = 1'b0;
                    we_d = 1'b0;
                    if (sel_q) mem_ack_d = 1'b1;
                    else       if_ack_d  = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel     = sel_q;
    assign ram_en  = en_q;
    assign ram_we  = we_q;
    assign if_ack  = if_ack_q;
    assign mem_ack = mem_ack_q;
    assign busy    = busy_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        sel, ram_en, ram_we, if_ack, mem_ack, busy;
    logic [31:0] rd_data;

    logic        req1 = 1'b0, req16 = 1'b0;
    logic        sel1, en1, we1, ifa1, mema1, busy1;
    logic        sel16, en16, we16, ifa16, mema16, busy16;
    logic [31:0] rd1, rd16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_SIZE(32), .LATENCY(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .mem_req(mem_req), .mem_wr(mem_wr),
        .ram_rdata(ram_rdata), .sel(sel), .ram_en(ram_en), .ram_we(ram_we),
        .if_ack(if_ack), .mem_ack(mem_ack), .rd_data(rd_data), .busy(busy));

    mem_port_arbiter #(.DATA_SIZE(32), .LATENCY(1), .CNT_W(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .if_req(req1), .mem_req(1'b0), .mem_wr(1'b0),
        .ram_rdata(ram_rdata), .sel(sel1), .ram_en(en1), .ram_we(we1),
        .if_ack(ifa1), .mem_ack(mema1), .rd_data(rd1), .busy(busy1));

    mem_port_arbiter #(.DATA_SIZE(32), .LATENCY(16), .CNT_W(4)) u_l16 (
        .clk(clk), .rst_n(rst_n), .if_req(req16), .mem_req(1'b0), .mem_wr(1'b0),
        .ram_rdata(ram_rdata), .sel(sel16), .ram_en(en16), .ram_we(we16),
        .if_ack(ifa16), .mem_ack(mema16), .rd_data(rd16), .busy(busy16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        if_req = 0; mem_req = 0; mem_wr = 0; req1 = 0; req16 = 0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        total++; if ({sel, ram_en, ram_we, if_ack, mem_ack, busy} !== 6'b0) begin bad++;
            $display("FAIL reset_ctrl got=%b exp=000000", {sel, ram_en, ram_we, if_ack, mem_ack, busy}); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
        rst_n = 1;
        tick();
        total++; if ({ram_en, busy} !== 2'b00) begin bad++; $display("FAIL idle_no_req got=%b exp=00", {ram_en, busy}); end
    endtask

    task automatic test_if_read();
        ram_rdata = 32'hDEADBEEF;
        if_req = 1;
        tick();
        total++; if ({sel, ram_en, ram_we, busy, if_ack} !== 5'b01010) begin bad++;
            $display("FAIL ifrd_t1 sel,en,we,busy,ack got=%b exp=01010", {sel, ram_en, ram_we, busy, if_ack}); end
        tick();
        total++; if ({ram_en, if_ack} !== 2'b10) begin bad++; $display("FAIL ifrd_t2 en,ack got=%b exp=10", {ram_en, if_ack}); end
        tick();
        total++; if ({if_ack, mem_ack, ram_en} !== 3'b100) begin bad++;
            $display("FAIL ifrd_t3 ifack,memack,en got=%b exp=100", {if_ack, mem_ack, ram_en}); end
        tick();
        if_req = 0;
        total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ifrd_data got=%h exp=deadbeef", rd_data); end
        total++; if ({if_ack, busy} !== 2'b00) begin bad++; $display("FAIL ifrd_t4 ack,busy got=%b exp=00", {if_ack, busy}); end
    endtask

    task automatic test_mem_write();
        ram_rdata = 32'h11111111;
        mem_req = 1; mem_wr = 1;
        tick();
        mem_wr = 0;
        total++; if ({sel, ram_en, ram_we} !== 3'b111) begin bad++; $display("FAIL wr_t1 sel,en,we got=%b exp=111", {sel, ram_en, ram_we}); end
        tick();
        total++; if ({ram_en, ram_we} !== 2'b11) begin bad++; $display("FAIL wr_t2 en,we got=%b exp=11", {ram_en, ram_we}); end
        tick();
        total++; if ({mem_ack, if_ack, ram_en, ram_we} !== 4'b1000) begin bad++;
            $display("FAIL wr_t3 memack,ifack,en,we got=%b exp=1000", {mem_ack, if_ack, ram_en, ram_we}); end
        total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_held got=%h exp=deadbeef", rd_data); end
        tick();
        mem_req = 0;
        tick();
    endtask

    task automatic test_no_double_grant();
        ram_rdata = 32'hC0FFEE01;
        mem_req = 1; mem_wr = 0;
        tick();
        total++; if ({sel, ram_we} !== 2'b10) begin bad++; $display("FAIL mrd_t1 sel,we got=%b exp=10", {sel, ram_we}); end
        tick();
        tick();
        total++; if (mem_ack !== 1'b1) begin bad++; $display("FAIL mrd_ack got=%b exp=1", mem_ack); end
        total++; if (rd_data !== 32'hC0FFEE01) begin bad++; $display("FAIL mrd_data got=%h exp=c0ffee01", rd_data); end
        tick();
        total++; if ({mem_ack, busy} !== 2'b00) begin bad++; $display("FAIL hold_idle ack,busy got=%b exp=00", {mem_ack, busy}); end
        mem_req = 0;
        ram_rdata = 32'h55555555;
        tick();
        total++; if ({ram_en, busy} !== 2'b00) begin bad++; $display("FAIL no_regrant en,busy got=%b exp=00", {ram_en, busy}); end
        total++; if (rd_data !== 32'hC0FFEE01) begin bad++; $display("FAIL idle_rd_held got=%h exp=c0ffee01", rd_data); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        int cyc;
        apply_reset();
        if_req = 1; mem_req = 1; mem_wr = 0;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!(if_ack || mem_ack) && cyc < 10);
`ifdef ARB_RR_EN
            exp_ack = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_ack = 2'b01;
`endif
            total++; if ({if_ack, mem_ack} !== exp_ack) begin bad++;
                $display("FAIL contend_%0d ifack,memack got=%b exp=%b", i, {if_ack, mem_ack}, exp_ack); end
            total++; if (cyc !== ((i == 0) ? 3 : 4)) begin bad++;
                $display("FAIL contend_gap_%0d got=%0d exp=%0d", i, cyc, (i == 0) ? 3 : 4); end
        end
        if_req = 0; mem_req = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        mem_req = 1; mem_wr = 1;
        tick();
        total++; if ({sel, ram_en, ram_we, busy} !== 4'b1111) begin bad++;
            $display("FAIL mid_pre got=%b exp=1111", {sel, ram_en, ram_we, busy}); end
        rst_n = 0;
        #1;
        total++; if ({sel, ram_en, ram_we, busy} !== 4'b0000) begin bad++;
            $display("FAIL mid_rst_async got=%b exp=0000", {sel, ram_en, ram_we, busy}); end
        mem_req = 0; mem_wr = 0;
        tick();
        tick();
        total++; if ({if_ack, mem_ack} !== 2'b00) begin bad++; $display("FAIL mid_no_ack got=%b exp=00", {if_ack, mem_ack}); end
        rst_n = 1;
        tick();
        ram_rdata = 32'hA5A5A5A5;
        if_req = 1;
        tick(); tick(); tick();
        total++; if ({if_ack, mem_ack} !== 2'b10) begin bad++; $display("FAIL post_rst_ack got=%b exp=10", {if_ack, mem_ack}); end
        tick();
        if_req = 0;
        total++; if (rd_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL post_rst_rd got=%h exp=a5a5a5a5", rd_data); end
    endtask

    task automatic test_latency();
        int en_cnt1 = 0, en_cnt16 = 0, ack_at1 = 0, ack_at16 = 0, first1 = 0, first16 = 0;
        req1 = 1; req16 = 1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (en1) begin en_cnt1++; if (first1 == 0) first1 = c; end
            if (en16) begin en_cnt16++; if (first16 == 0) first16 = c; end
            if (ifa1) begin ack_at1 = c; req1 = 0; end
            if (ifa16) begin ack_at16 = c; req16 = 0; end
        end
        total++; if (en_cnt1 !== 1) begin bad++; $display("FAIL lat1_en_width got=%0d exp=1", en_cnt1); end
        total++; if (first1 !== 1 || ack_at1 !== 2) begin bad++;
            $display("FAIL lat1_timing first_en=%0d ack=%0d exp=1,2", first1, ack_at1); end
        total++; if (en_cnt16 !== 16) begin bad++; $display("FAIL lat16_en_width got=%0d exp=16", en_cnt16); end
        total++; if (first16 !== 1 || ack_at16 !== 17) begin bad++;
            $display("FAIL lat16_timing first_en=%0d ack=%0d exp=1,17", first16, ack_at16); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_no_double_grant();
        test_contention();
        test_reset_mid();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
